// File: rtl/simon_pkg.sv
// Shared types and default timing constants for the Simon colour-sequence game.
// Imported by the sequencer, its storage sub-module and the bus interface.
package simon_pkg;

    typedef enum logic [1:0] {
        RED    = 2'd0,
        GREEN  = 2'd1,
        BLUE   = 2'd2,
        YELLOW = 2'd3
    } color_t;

    typedef enum logic [2:0] {
        SEQ_IDLE     = 3'd0,
        SEQ_APPEND   = 3'd1,
        SEQ_SHOW_ON  = 3'd2,
        SEQ_SHOW_GAP = 3'd3,
        SEQ_WAIT_IN  = 3'd4,
        SEQ_WIN      = 3'd5,
        SEQ_LOSE     = 3'd6
    } seq_state_t;

    localparam int unsigned DEF_MAX_LEN     = 32;
    localparam int unsigned DEF_SHOW_CYCLES = 4;
    localparam int unsigned DEF_GAP_CYCLES  = 2;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Only the two low LFSR bits pick a colour; the upper bits are deliberately discarded.
    function automatic color_t lfsr_color(input logic [4:0] lfsr);
        return color_t'(lfsr[1:0]);
    endfunction

endpackage

// File: rtl/simon_if.sv
// Bus between the Simon sequencer and the LFSR / display / button front-end.
// master = front-end side, slave = sequencer side.
interface simon_if #(
    parameter int unsigned MAX_LEN = simon_pkg::DEF_MAX_LEN
);
    localparam int unsigned LEN_W = $clog2(MAX_LEN) + 1;

    logic [4:0]       lfsr_data;
    logic             start;
    logic             btn_valid;
    logic [1:0]       btn_color;
    logic             show_valid;
    logic [1:0]       show_color;
    logic             await_input;
    logic [LEN_W-1:0] round_len;
    logic             win;
    logic             lose;

    modport master (
        output lfsr_data, start, btn_valid, btn_color,
        input  show_valid, show_color, await_input, round_len, win, lose
    );

    modport slave (
        input  lfsr_data, start, btn_valid, btn_color,
        output show_valid, show_color, await_input, round_len, win, lose
    );

endinterface

// File: rtl/simon_seq_mem.sv
// Colour sequence storage: DEPTH x 2-bit register array, one synchronous write
// port and one asynchronous read port. Contents are not reset.
module simon_seq_mem
    import simon_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_MAX_LEN,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  color_t        wdata,
    input  logic [AW-1:0] raddr,
    output color_t        rdata
);

    color_t mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/simon_sequencer.sv
// Simon sequencer: grows a random colour sequence each round, plays it out,
// then checks player presses against it and reports win / lose.
module simon_sequencer
    import simon_pkg::*;
#(
    parameter int unsigned MAX_LEN     = DEF_MAX_LEN,
    parameter int unsigned SHOW_CYCLES = DEF_SHOW_CYCLES,
    parameter int unsigned GAP_CYCLES  = DEF_GAP_CYCLES
) (
    input logic    clk,
    input logic    rst,
    simon_if.slave bus
);

    localparam int unsigned AW = $clog2(MAX_LEN);
    localparam int unsigned LW = $clog2(MAX_LEN) + 1;
    localparam int unsigned TW = $clog2(max_u(SHOW_CYCLES, GAP_CYCLES)) + 1;

    localparam logic [TW-1:0] SHOW_LAST = TW'(SHOW_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_CYCLES - 1);
    localparam logic [LW-1:0] LEN_MAX   = LW'(MAX_LEN);

    seq_state_t    state_q, state_d;
    logic [LW-1:0] len_q,   len_d;
    logic [AW-1:0] idx_q,   idx_d;
    logic [TW-1:0] timer_q, timer_d;

    logic   mem_we;
    color_t mem_rdata;
    logic   idx_is_last;

    simon_seq_mem #(
        .DEPTH (MAX_LEN),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (len_q[AW-1:0]),
        .wdata (lfsr_color(bus.lfsr_data)),
        .raddr (idx_q),
        .rdata (mem_rdata)
    );

    assign idx_is_last = ({1'b0, idx_q} == (len_q - LW'(1)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SEQ_IDLE;
            len_q   <= '0;
            idx_q   <= '0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            timer_q <= timer_d;
        end
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        timer_d = timer_q;
        mem_we  = 1'b0;

        unique case (state_q)
            SEQ_IDLE, SEQ_WIN, SEQ_LOSE: begin
                if (bus.start) begin
                    len_d   = '0;
                    state_d = SEQ_APPEND;
                end
            end

            SEQ_APPEND: begin
                mem_we  = 1'b1;
                len_d   = len_q + LW'(1);
                idx_d   = '0;
                timer_d = '0;
                state_d = SEQ_SHOW_ON;
            end

            SEQ_SHOW_ON: begin
                if (timer_q == SHOW_LAST) begin
                    timer_d = '0;
                    state_d = SEQ_SHOW_GAP;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end

            SEQ_SHOW_GAP: begin
                if (timer_q == GAP_LAST) begin
                    timer_d = '0;
                    if (idx_is_last) begin
                        idx_d   = '0;
                        state_d = SEQ_WAIT_IN;
                    end else begin
                        idx_d   = idx_q + AW'(1);
                        state_d = SEQ_SHOW_ON;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end

            // A full-length correct sequence wins; APPEND is only reached below MAX_LEN, so len never wraps.
            SEQ_WAIT_IN: begin
                if (bus.btn_valid) begin
                    if (bus.btn_color != mem_rdata) begin
                        state_d = SEQ_LOSE;
                    end else if (!idx_is_last) begin
                        idx_d = idx_q + AW'(1);
                    end else if (len_q == LEN_MAX) begin
                        state_d = SEQ_WIN;
                    end else begin
                        state_d = SEQ_APPEND;
                    end
                end
            end

            default: begin
                state_d = SEQ_IDLE;
            end
        endcase
    end

    always_comb begin
        bus.show_valid  = (state_q == SEQ_SHOW_ON);
        bus.show_color  = (state_q == SEQ_SHOW_ON) ? mem_rdata : 2'd0;
        bus.await_input = (state_q == SEQ_WAIT_IN);
        bus.round_len   = len_q;
        bus.win         = (state_q == SEQ_WIN);
        bus.lose        = (state_q == SEQ_LOSE);
    end

endmodule

// File: tb/tb_simon_sequencer.sv
// Self-checking bench for simon_sequencer: a directed vector table, hand-written
// corner sequences, and random games checked against a queue-based game model.
module tb_simon_sequencer;
    import simon_pkg::*;

    localparam int unsigned MAX_LEN = 4;
    localparam int unsigned SHOW_N  = 4;
    localparam int unsigned GAP_N   = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    simon_if #(.MAX_LEN(MAX_LEN)) bus();

    simon_sequencer #(
        .MAX_LEN     (MAX_LEN),
        .SHOW_CYCLES (SHOW_N),
        .GAP_CYCLES  (GAP_N)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks = 0;
    int errors = 0;
    int exp_seq[$];

    typedef struct {
        bit        rst;
        bit        start;
        bit        btn_v;
        bit [1:0]  btn_c;
        bit [4:0]  lfsr;
        bit [31:0] exp;
        string     name;
    } vec_t;

    vec_t vecs[$];

    function automatic bit [31:0] ev(int sv, int sc, int aw, int rl, int w, int l);
        return 32'((sv << 24) | (sc << 20) | (aw << 16) | (rl << 8) | (w << 4) | l);
    endfunction

    function automatic logic [31:0] act_vec();
        return {7'b0, bus.show_valid, 2'b0, bus.show_color, 3'b0, bus.await_input,
                4'b0, 1'b0, bus.round_len, 3'b0, bus.win, 3'b0, bus.lose};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic obs(string name, bit [31:0] exp);
        logic [31:0] a;
        a = act_vec();
        checks++;
        if (a !== exp) begin
            errors++;
            $display("FAIL %s: got sv/sc/aw/len/win/lose=%07h expected %07h at %0t", name, a, exp, $time);
        end
    endtask

    task automatic drive(bit s, bit bv, bit [1:0] bc);
        bus.start     = s;
        bus.btn_valid = bv;
        bus.btn_color = bc;
    endtask

    task automatic press(bit [1:0] c);
        drive(1'b0, 1'b1, c);
        step();
        drive(1'b0, 1'b0, 2'd0);
    endtask

    // Entered on the first displayed cycle; leaves in WAIT_IN with await_input checked.
    task automatic play_check(bit inject);
        int n;
        n = exp_seq.size();
        foreach (exp_seq[i]) begin
            for (int c = 0; c < int'(SHOW_N); c++) begin
                obs("show_on", ev(1, exp_seq[i], 0, n, 0, 0));
                if (inject) drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
                step();
                drive(1'b0, 1'b0, 2'd0);
            end
            for (int g = 0; g < int'(GAP_N); g++) begin
                obs("show_gap", ev(0, 0, 0, n, 0, 0));
                if (inject) drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
                step();
                drive(1'b0, 1'b0, 2'd0);
            end
        end
        obs("await", ev(0, 0, 1, n, 0, 0));
    endtask

    task automatic play_game(int err_pct);
        bit [4:0] nl;
        bit       done;
        int       n;
        bit       ok;
        bit [1:0] col;
        exp_seq.delete();
        nl = 5'($urandom);
        bus.lfsr_data = nl;
        drive(1'b1, 1'b0, 2'd0);
        step();
        drive(1'b0, 1'b0, 2'd0);
        obs("g_append0", ev(0, 0, 0, 0, 0, 0));
        exp_seq.push_back(int'(nl[1:0]));
        step();
        done = 1'b0;
        while (!done) begin
            play_check(1'($urandom_range(0, 1)));
            n = exp_seq.size();
            for (int i = 0; i < n; i++) begin
                for (int k = $urandom_range(0, 2); k > 0; k--) begin
                    drive(1'($urandom_range(0, 1)), 1'b0, 2'd0);
                    step();
                    drive(1'b0, 1'b0, 2'd0);
                    obs("g_wait_idle", ev(0, 0, 1, n, 0, 0));
                end
                ok  = ($urandom_range(0, 99) >= err_pct);
                col = ok ? 2'(exp_seq[i]) : 2'(exp_seq[i] + $urandom_range(1, 3));
                if (ok && i == n - 1 && n < int'(MAX_LEN)) begin
                    nl = 5'($urandom);
                    bus.lfsr_data = nl;
                end
                press(col);
                if (!ok) begin
                    obs("g_lose", ev(0, 0, 0, n, 0, 1));
                    press(2'(exp_seq[i]));
                    obs("g_lose_hold", ev(0, 0, 0, n, 0, 1));
                    done = 1'b1;
                    break;
                end else if (i < n - 1) begin
                    obs("g_next_press", ev(0, 0, 1, n, 0, 0));
                end else if (n == int'(MAX_LEN)) begin
                    obs("g_win", ev(0, 0, 0, n, 1, 0));
                    press(2'($urandom_range(0, 3)));
                    obs("g_win_hold", ev(0, 0, 0, n, 1, 0));
                    done = 1'b1;
                end else begin
                    obs("g_append", ev(0, 0, 0, n, 0, 0));
                    exp_seq.push_back(int'(nl[1:0]));
                    step();
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.lfsr_data = 5'h00;
        drive(1'b0, 1'b0, 2'd0);

        //                 rst  st  bv  bc    lfsr   expected                 name
        vecs.push_back('{1'b1, 0, 0, 2'd0, 5'h1f, ev(0, 0, 0, 0, 0, 0), "reset"});
        vecs.push_back('{1'b0, 0, 0, 2'd0, 5'h1f, ev(0, 0, 0, 0, 0, 0), "idle"});
        vecs.push_back('{1'b0, 0, 1, 2'd3, 5'h1f, ev(0, 0, 0, 0, 0, 0), "idle_btn"});
        vecs.push_back('{1'b0, 1, 0, 2'd0, 5'h1f, ev(0, 0, 0, 0, 0, 0), "append"});
        vecs.push_back('{1'b0, 0, 0, 2'd0, 5'h1f, ev(1, 3, 0, 1, 0, 0), "on1"});
        vecs.push_back('{1'b0, 0, 1, 2'd1, 5'h1f, ev(1, 3, 0, 1, 0, 0), "on2_btn"});
        vecs.push_back('{1'b0, 1, 0, 2'd0, 5'h1f, ev(1, 3, 0, 1, 0, 0), "on3_start"});
        vecs.push_back('{1'b0, 0, 0, 2'd0, 5'h1f, ev(1, 3, 0, 1, 0, 0), "on4"});
        vecs.push_back('{1'b0, 0, 1, 2'd0, 5'h1f, ev(0, 0, 0, 1, 0, 0), "gap1_btn"});
        vecs.push_back('{1'b0, 0, 0, 2'd0, 5'h1f, ev(0, 0, 0, 1, 0, 0), "gap2"});
        vecs.push_back('{1'b0, 0, 0, 2'd0, 5'h1f, ev(0, 0, 1, 1, 0, 0), "wait"});
        vecs.push_back('{1'b0, 1, 0, 2'd0, 5'h1f, ev(0, 0, 1, 1, 0, 0), "wait_start"});
        vecs.push_back('{1'b0, 0, 1, 2'd0, 5'h1f, ev(0, 0, 0, 1, 0, 1), "wrong_press"});
        vecs.push_back('{1'b0, 0, 1, 2'd3, 5'h1f, ev(0, 0, 0, 1, 0, 1), "lose_press"});
        vecs.push_back('{1'b0, 0, 0, 2'd0, 5'h1f, ev(0, 0, 0, 1, 0, 1), "lose_hold"});
        vecs.push_back('{1'b0, 1, 0, 2'd0, 5'h1f, ev(0, 0, 0, 0, 0, 0), "restart"});
        vecs.push_back('{1'b0, 0, 0, 2'd0, 5'h1f, ev(1, 3, 0, 1, 0, 0), "restart_on"});

        foreach (vecs[i]) begin
            rst           = vecs[i].rst;
            bus.lfsr_data = vecs[i].lfsr;
            drive(vecs[i].start, vecs[i].btn_v, vecs[i].btn_c);
            step();
            obs(vecs[i].name, vecs[i].exp);
        end
        drive(1'b0, 1'b0, 2'd0);

        // Round 1 playback from the current SHOW_ON cycle, then grow to [3,2].
        exp_seq.delete();
        exp_seq.push_back(3);
        play_check(1'b0);
        bus.lfsr_data = 5'h0a;
        press(2'd3);
        obs("last_press_latency", ev(0, 0, 0, 1, 0, 0));
        exp_seq.push_back(2);
        step();
        play_check(1'b1);
        press(2'd3);
        obs("mid_press", ev(0, 0, 1, 2, 0, 0));

        // Reset in the middle of a display.
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.lfsr_data = 5'h05;
        drive(1'b1, 1'b0, 2'd0);
        step();
        drive(1'b0, 1'b0, 2'd0);
        step();
        obs("pre_rst_on", ev(1, 1, 0, 1, 0, 0));
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        obs("rst_mid_show", ev(0, 0, 0, 0, 0, 0));
        step();
        obs("rst_idle", ev(0, 0, 0, 0, 0, 0));

        play_game(0);
        for (int g = 0; g < 12; g++) begin
            play_game(12);
        end
        play_game(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
